// File: rtl/dram_shifter_pkg.sv
// dram_shifter_pkg: shared types and sizing helpers for the 1-bit distributed-RAM shifter path.
// Rev 1.0
`default_nettype none

package dram_shifter_pkg;

  localparam int DEF_IO_WIDTH   = 16;
  localparam int DEF_ADDR_WIDTH = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_PRESENT = 2'd2
  } coll_state_e;

  function automatic int calc_widx(input int addr_w, input int io_w);
    return addr_w - $clog2(io_w);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dram_bit_deserializer.sv
// dram_bit_deserializer: LSB-first 1-bit to IO_WIDTH-bit shift register with bit counter.
// Rev 1.0
`default_nettype none

module dram_bit_deserializer
  import dram_shifter_pkg::*;
#(
  parameter int IO_WIDTH = DEF_IO_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear_i,
  input  logic                shift_en_i,
  input  logic                bit_i,
  output logic [IO_WIDTH-1:0] word_o,
  output logic                word_done_o
);

  localparam int LOG_W = $clog2(IO_WIDTH);

  logic [IO_WIDTH-1:0] shreg_q, shreg_d;
  logic [LOG_W-1:0]    cnt_q;

  // New bit enters at the top; after IO_WIDTH shifts the first bit sits at bit 0.
  assign shreg_d     = IO_WIDTH'({bit_i, shreg_q} >> 1);
  assign word_o      = shreg_d;
  assign word_done_o = shift_en_i && (cnt_q == LOG_W'(IO_WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (clear_i) begin
      cnt_q   <= '0;
    end else if (shift_en_i) begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_q + LOG_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/dram_readback_collector.sv
// dram_readback_collector: sweeps a 1-bit RAM and delivers IO_WIDTH-bit words on valid/ready.
// Optional out_parity port when DRAM_COLLECTOR_PARITY_EN is defined. Rev 1.0
`default_nettype none

module dram_readback_collector
  import dram_shifter_pkg::*;
#(
  parameter int IO_WIDTH   = DEF_IO_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  localparam int WIDX      = calc_widx(ADDR_WIDTH, IO_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDX-1:0]       first_word,
  input  logic [WIDX-1:0]       last_word,
  output logic [ADDR_WIDTH-1:0] addr,
  input  logic                  ram_out,
  output logic [IO_WIDTH-1:0]   out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
`ifdef DRAM_COLLECTOR_PARITY_EN
  ,
  output logic                  out_parity
`endif
);

  localparam int LOG_W = $clog2(IO_WIDTH);

  coll_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDX-1:0]       last_q, last_d;
  logic [WIDX-1:0]       widx_q, widx_d;
  logic [IO_WIDTH-1:0]   data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic                  clr, shift_en, word_done;
  logic [IO_WIDTH-1:0]   word;
`ifdef DRAM_COLLECTOR_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  dram_bit_deserializer #(
    .IO_WIDTH (IO_WIDTH)
  ) u_deser (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (clr),
    .shift_en_i  (shift_en),
    .bit_i       (ram_out),
    .word_o      (word),
    .word_done_o (word_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      last_q   <= '0;
      widx_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef DRAM_COLLECTOR_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      last_q   <= last_d;
      widx_q   <= widx_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
`ifdef DRAM_COLLECTOR_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    last_d   = last_q;
    widx_d   = widx_q;
    data_d   = data_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    clr      = 1'b0;
    shift_en = 1'b0;
`ifdef DRAM_COLLECTOR_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          last_d  = last_word;
          widx_d  = first_word;
          addr_d  = {first_word, {LOG_W{1'b0}}};
          clr     = 1'b1;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        shift_en = 1'b1;
        addr_d   = addr_q + ADDR_WIDTH'(1);
        if (word_done) begin
          data_d  = word;
          valid_d = 1'b1;
`ifdef DRAM_COLLECTOR_PARITY_EN
          parity_d = ^word;
`endif
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        // addr already points at the next word, so only the word index advances here.
        if (out_ready) begin
          valid_d = 1'b0;
          if (widx_q == last_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            widx_d  = widx_q + WIDX'(1);
            clr     = 1'b1;
            state_d = ST_READ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign addr      = addr_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
`ifdef DRAM_COLLECTOR_PARITY_EN
  assign out_parity = parity_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dram_readback_collector.sv
// tb_dram_readback_collector: directed self-checking bench with a 128x1 RAM model.
// Rev 1.0
`default_nettype none

module tb_dram_readback_collector;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   first_word;
  logic [2:0]   last_word;
  logic [6:0]   addr;
  logic         ram_out;
  logic [15:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         done;
`ifdef DRAM_COLLECTOR_PARITY_EN
  logic         out_parity;
`endif
  logic [127:0] ram;
  int           n_cmp  = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;

  assign ram_out = ram[addr];

  dram_readback_collector #(
    .IO_WIDTH   (16),
    .ADDR_WIDTH (7)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .first_word (first_word),
    .last_word  (last_word),
    .addr       (addr),
    .ram_out    (ram_out),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done)
`ifdef DRAM_COLLECTOR_PARITY_EN
    ,
    .out_parity (out_parity)
`endif
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic kick(input logic [2:0] fw, input logic [2:0] lw);
    first_word = fw;
    last_word  = lw;
    start      = 1'b1;
    tick(1);
    start      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(5);
    n_cmp++; if (addr !== 7'd0)      begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", addr); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_data !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0000", out_data); end
    n_cmp++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
  endtask

  task automatic test_single_word();
    ram       = {8{16'h96A5}};
    out_ready = 1'b1;
    kick(3'd0, 3'd0);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", busy); end
    tick(15);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b expected 0", out_valid); end
    tick(1);
    n_cmp++; if (out_valid !== 1'b1)   begin n_fail++; $display("FAIL single_valid: got %b expected 1", out_valid); end
    n_cmp++; if (out_data !== 16'h96A5) begin n_fail++; $display("FAIL single_data: got %h expected 96a5", out_data); end
    n_cmp++; if (addr !== 7'd16)        begin n_fail++; $display("FAIL single_addr: got %0d expected 16", addr); end
`ifdef DRAM_COLLECTOR_PARITY_EN
    n_cmp++; if (out_parity !== 1'b0) begin n_fail++; $display("FAIL parity_96a5: got %b expected 0", out_parity); end
`endif
    tick(1);
    n_cmp++; if (done !== 1'b1)      begin n_fail++; $display("FAIL single_done: got %b expected 1", done); end
    n_cmp++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL single_busy_fall: got %b expected 0", busy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_fall: got %b expected 0", out_valid); end
    tick(1);
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_backpressure();
    ram       = {8{16'h96A5}};
    out_ready = 1'b0;
    kick(3'd0, 3'd0);
    tick(16);
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (out_valid !== 1'b1)    begin n_fail++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, out_valid); end
      n_cmp++; if (out_data !== 16'h96A5) begin n_fail++; $display("FAIL bp_data[%0d]: got %h expected 96a5", i, out_data); end
      n_cmp++; if (addr !== 7'd16)        begin n_fail++; $display("FAIL bp_addr[%0d]: got %0d expected 16", i, addr); end
      n_cmp++; if (done !== 1'b0)         begin n_fail++; $display("FAIL bp_done[%0d]: got %b expected 0", i, done); end
      tick(1);
    end
    out_ready = 1'b1;
    tick(1);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_accept_valid: got %b expected 0", out_valid); end
    n_cmp++; if (done !== 1'b1)      begin n_fail++; $display("FAIL bp_accept_done: got %b expected 1", done); end
  endtask

  task automatic test_wrap();
    ram           = '0;
    ram[127:112]  = 16'hBEEF;
    ram[15:0]     = 16'h1234;
    out_ready     = 1'b1;
    kick(3'd7, 3'd0);
    tick(16);
    n_cmp++; if (out_valid !== 1'b1)    begin n_fail++; $display("FAIL wrap_valid0: got %b expected 1", out_valid); end
    n_cmp++; if (out_data !== 16'hBEEF) begin n_fail++; $display("FAIL wrap_data0: got %h expected beef", out_data); end
    n_cmp++; if (addr !== 7'd0)         begin n_fail++; $display("FAIL wrap_addr0: got %0d expected 0", addr); end
    tick(1);
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL wrap_mid_done: got %b expected 0", done); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wrap_mid_busy: got %b expected 1", busy); end
    tick(15);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_early_valid1: got %b expected 0", out_valid); end
    tick(1);
    n_cmp++; if (out_valid !== 1'b1)    begin n_fail++; $display("FAIL wrap_valid1: got %b expected 1", out_valid); end
    n_cmp++; if (out_data !== 16'h1234) begin n_fail++; $display("FAIL wrap_data1: got %h expected 1234", out_data); end
    n_cmp++; if (addr !== 7'd16)        begin n_fail++; $display("FAIL wrap_addr1: got %0d expected 16", addr); end
    tick(1);
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL wrap_done: got %b expected 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wrap_busy_fall: got %b expected 0", busy); end
  endtask

  task automatic test_start_while_busy();
    ram       = {8{16'h96A5}};
    out_ready = 1'b1;
    kick(3'd0, 3'd0);
    tick(5);
    kick(3'd3, 3'd3);
    n_cmp++; if (addr !== 7'd6) begin n_fail++; $display("FAIL busy_start_addr: got %0d expected 6", addr); end
    tick(10);
    n_cmp++; if (out_valid !== 1'b1)    begin n_fail++; $display("FAIL busy_start_valid: got %b expected 1", out_valid); end
    n_cmp++; if (out_data !== 16'h96A5) begin n_fail++; $display("FAIL busy_start_data: got %h expected 96a5", out_data); end
    tick(1);
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL busy_start_done: got %b expected 1", done); end
  endtask

  task automatic test_reset_mid_read();
    ram       = {8{16'h96A5}};
    out_ready = 1'b1;
    kick(3'd0, 3'd0);
    tick(7);
    rst = 1'b1;
    tick(1);
    n_cmp++; if (addr !== 7'd0)      begin n_fail++; $display("FAIL midrst_addr: got %0d expected 0", addr); end
    n_cmp++; if (out_data !== 16'h0) begin n_fail++; $display("FAIL midrst_data: got %h expected 0000", out_data); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
    n_cmp++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0)      begin n_fail++; $display("FAIL midrst_done: got %b expected 0", done); end
    rst         = 1'b0;
    ram[47:32]  = 16'h0001;
    kick(3'd2, 3'd2);
    tick(16);
    n_cmp++; if (out_valid !== 1'b1)    begin n_fail++; $display("FAIL restart_valid: got %b expected 1", out_valid); end
    n_cmp++; if (out_data !== 16'h0001) begin n_fail++; $display("FAIL restart_data: got %h expected 0001", out_data); end
    n_cmp++; if (addr !== 7'd48)        begin n_fail++; $display("FAIL restart_addr: got %0d expected 48", addr); end
`ifdef DRAM_COLLECTOR_PARITY_EN
    n_cmp++; if (out_parity !== 1'b1) begin n_fail++; $display("FAIL parity_0001: got %b expected 1", out_parity); end
`endif
    tick(1);
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL restart_done: got %b expected 1", done); end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    first_word = '0;
    last_word  = '0;
    out_ready  = 1'b0;
    ram        = '0;
    @(negedge clk);
    test_reset();
    test_single_word();
    test_backpressure();
    test_wrap();
    test_start_while_busy();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dram_readback_collector.md
# dram_readback_collector

Downstream stage of the 1-bit distributed-RAM shifter path. It sweeps the address port of a RAM with one data bit per address, such as a RAM256X1S or RAM128X1S, and samples the asynchronous read data one bit per cycle. It assembles IO_WIDTH-bit words and presents each word on a valid/ready output, so the RAM contents can be read back as parallel words for LEDs, a UART or a checker.

## Interface
- IO_WIDTH, 16, bits per word; power of two, at least 2.
- ADDR_WIDTH, 7, RAM address width. The RAM holds 2^ADDR_WIDTH bits, which is NUM_WORDS = 2^ADDR_WIDTH / IO_WIDTH words.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  sweep request; sampled only in IDLE.
- first_word  in  WIDX = ADDR_WIDTH - log2(IO_WIDTH)  first word index of the sweep.
- last_word  in  WIDX  last word index, inclusive; captured with start.
- addr  out  ADDR_WIDTH  RAM read address; registered.
- ram_out  in  1  RAM asynchronous read data for the current addr.
- out_data  out  IO_WIDTH  assembled word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the word.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse after the last word is accepted.

## Operation
- Bit i of word w is at address w*IO_WIDTH + i. Bits are collected LSB first. Shift register update: shreg <= {ram_out, shreg[IO_WIDTH-1:1]}.
- FSM states: IDLE, READ, PRESENT.
- IDLE, start=1:
  - capture last_word;
  - addr <= first_word*IO_WIDTH;
  - bit_cnt <= 0;
  - next state READ.
  - start while busy is ignored.
- READ, every cycle:
  - shift in ram_out;
  - addr <= addr+1, modulo 2^ADDR_WIDTH;
  - bit_cnt <= bit_cnt+1.
  - When bit_cnt == IO_WIDTH-1: out_data <= final shifted value, out_valid <= 1, next state PRESENT.
- PRESENT, out_valid=1:
  - out_data and addr are held stable.
  - On an edge with out_ready=1: out_valid <= 0.
  - If the word just accepted was at index last_word: done pulses for one cycle and the state returns to IDLE.
  - Otherwise: bit_cnt <= 0 and the state returns to READ. addr already points at the next word.
- Word index arithmetic is modulo NUM_WORDS. If last_word < first_word the sweep wraps through the top word to index 0. If first_word == last_word exactly one word is read. A full sweep needs last_word = first_word-1, which gives NUM_WORDS words.
- Reset, including mid-sweep: state IDLE, addr=0, out_data=0, out_valid=0, busy=0, done=0, shreg=0. Any partial word is discarded.

## Timing
- Start sampled at edge E0 gives out_valid=1 after edge E0+IO_WIDTH. Latency is IO_WIDTH+1 cycles from the start cycle.
- ram_out is sampled on the same edge that addr is presented. The RAM read path is combinational, with no extra wait state.
- Back-to-back words with out_ready held high take IO_WIDTH+1 cycles each: one PRESENT cycle plus IO_WIDTH READ cycles.
- done is asserted in the cycle after the accepting edge. busy falls in the same cycle.
- out_valid never drops without a handshake, except on rst.

## Configuration
- DRAM_COLLECTOR_PARITY_EN defined:
  - extra output out_parity (1 bit), the even-parity XOR of out_data;
  - registered together with out_data and valid under the same handshake;
  - reset value 0.
- Macro undefined: the port and its logic are absent and behaviour is otherwise identical.

## Structure
- Shared package dram_shifter_pkg holds:
  - the state enum (IDLE/READ/PRESENT);
  - the WIDX calculation helper;
  - the default IO_WIDTH and ADDR_WIDTH constants used by the shifter tests.
- One sub-module, dram_bit_deserializer: shreg, bit_cnt, word-complete flag. The top level keeps the FSM, address counter and handshake.

## Test plan
- Reset, then idle 5 cycles -> addr=0, out_valid=0, out_data=0, busy=0, done=0.
- RAM INIT 256'h96A5 repeated, ADDR_WIDTH=8, start with first_word=0 and last_word=0, out_ready=1:
  - out_valid rises 17 cycles after the start cycle;
  - out_data=16'h96A5;
  - done pulses once.
- Same RAM, out_ready held low 5 cycles during PRESENT -> out_data stays 16'h96A5, addr stays 16, out_valid stays high; the word is accepted on the first ready edge.
- ADDR_WIDTH=7, first_word=7, last_word=0 -> two words delivered; addr wraps 127->0; done follows the second handshake.
- Stimulus for start and reset while busy:
  - start pulsed during READ -> no effect on addr or word count;
  - rst asserted mid-READ -> all outputs at reset values the next cycle;
  - a new start afterwards -> first word correct.
- DRAM_COLLECTOR_PARITY_EN defined -> out_parity=0 for 16'h96A5 and 1 for 16'h0001.
